// File: rtl/tone_out_pkg.sv
// Shared constants for the audio DAC output stage: ramp state encoding, attenuation limit,
// dither LFSR seed/taps and the two's-complement to offset-binary helper.
package tone_out_pkg;

  localparam logic [1:0] PLAY     = 2'd0;
  localparam logic [1:0] FADE_OUT = 2'd1;
  localparam logic [1:0] MUTED    = 2'd2;
  localparam logic [1:0] FADE_IN  = 2'd3;

  localparam logic [4:0]  ATTEN_MAX = 5'd16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 mapped onto bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] to_offset_binary(input logic [15:0] s);
    return {~s[15], s[14:0]};
  endfunction

endpackage

// File: rtl/audio_dac_out_if.sv
// Sample/control bundle between the mixer and the DAC output stage.
interface audio_dac_out_if;

  logic [15:0] data_in;
  logic        data_valid_in;
  logic        mute_in;
  logic        pdm_out;
  logic        muted_out;
  logic        starved_out;

  modport master (
    output data_in, data_valid_in, mute_in,
    input  pdm_out, muted_out, starved_out
  );

  modport slave (
    input  data_in, data_valid_in, mute_in,
    output pdm_out, muted_out, starved_out
  );

endinterface

// File: rtl/dsm_modulator.sv
// First-order delta-sigma modulator: 16-bit accumulator, carry out is the PDM bit.
// Optional LFSR dither on the accumulator input when DAC_DITHER_EN is defined.
module dsm_modulator
  import tone_out_pkg::*;
(
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic signed [15:0] sample_in,
  output logic               pdm_out
);

  logic [15:0] acc_q, acc_d;
  logic        pdm_q, pdm_d;
  logic [16:0] sum;

`ifdef DAC_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    sum    = {1'b0, acc_q} + {1'b0, to_offset_binary(sample_in)} + {13'd0, lfsr_q[3:0]};
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end
`else
  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, to_offset_binary(sample_in)};
  end
`endif

  always_comb begin
    acc_d = sum[15:0];
    pdm_d = sum[16];
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      acc_q <= 16'd0;
      pdm_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      pdm_q <= pdm_d;
    end
  end

  assign pdm_out = pdm_q;

endmodule

// File: rtl/audio_dac_out.sv
// Mixer-to-RC-filter output stage: soft-mute shift ramp, sample hold, starvation watchdog, PDM modulator.
// Define DAC_DITHER_EN to enable LFSR dither inside the modulator.
module audio_dac_out
  import tone_out_pkg::*;
#(
  parameter int WATCHDOG_CYCLES = 2048
) (
  input logic            clk_in,
  input logic            reset_in,
  audio_dac_out_if.slave bus
);

  localparam int              WD_W   = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WATCHDOG_CYCLES);

  logic [1:0]        state_q, state_d;
  logic [4:0]        atten_q, atten_d;
  logic signed [15:0] hold_q, hold_d;
  logic              muted_q, muted_d;
  logic              starved_q, starved_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic [4:0]        atten_up, atten_dn;
  logic signed [15:0] data_s;
  logic              pdm_w;

  assign data_s   = bus.data_in;
  assign atten_up = (atten_q >= ATTEN_MAX) ? ATTEN_MAX : atten_q + 5'd1;
  assign atten_dn = (atten_q == 5'd0) ? 5'd0 : atten_q - 5'd1;

  // Ramp only moves on strobes; a fade may reverse direction at any step
  always_comb begin
    state_d = state_q;
    atten_d = atten_q;
    if (bus.data_valid_in) begin
      case (state_q)
        PLAY: begin
          if (bus.mute_in) begin
            state_d = FADE_OUT;
            atten_d = 5'd1;
          end else begin
            atten_d = 5'd0;
          end
        end
        FADE_OUT, FADE_IN: begin
          if (bus.mute_in) begin
            atten_d = atten_up;
            state_d = (atten_up == ATTEN_MAX) ? MUTED : FADE_OUT;
          end else begin
            atten_d = atten_dn;
            state_d = (atten_dn == 5'd0) ? PLAY : FADE_IN;
          end
        end
        default: begin
          if (!bus.mute_in) begin
            state_d = FADE_IN;
            atten_d = 5'd15;
          end else begin
            atten_d = ATTEN_MAX;
          end
        end
      endcase
    end
  end

  always_comb begin
    hold_d = hold_q;
    if (bus.data_valid_in) begin
      hold_d = (atten_d == ATTEN_MAX) ? 16'sd0 : (data_s >>> atten_d);
    end
  end

  // A strobe in the saturating cycle still clears the watchdog
  always_comb begin
    if (bus.data_valid_in) begin
      wd_cnt_d  = '0;
      starved_d = 1'b0;
    end else begin
      wd_cnt_d  = (wd_cnt_q == WD_MAX) ? WD_MAX : wd_cnt_q + WD_W'(1);
      starved_d = (wd_cnt_d == WD_MAX);
    end
    muted_d = (state_q == MUTED);
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q   <= MUTED;
      atten_q   <= ATTEN_MAX;
      hold_q    <= 16'sd0;
      muted_q   <= 1'b1;
      starved_q <= 1'b0;
      wd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      atten_q   <= atten_d;
      hold_q    <= hold_d;
      muted_q   <= muted_d;
      starved_q <= starved_d;
      wd_cnt_q  <= wd_cnt_d;
    end
  end

  dsm_modulator u_mod (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .sample_in (hold_q),
    .pdm_out   (pdm_w)
  );

  assign bus.pdm_out     = pdm_w;
  assign bus.muted_out   = muted_q;
  assign bus.starved_out = starved_q;

endmodule

// File: tb/tb_audio_dac_out.sv
// Directed bench for audio_dac_out: fade-in ramp, PDM duty, fade reversal, watchdog, mid-ramp reset.
module tb_audio_dac_out;
  import tone_out_pkg::*;

  logic clk_in   = 1'b0;
  logic reset_in = 1'b1;
  int   checks   = 0;
  int   errors   = 0;
  int   ones;

  audio_dac_out_if bus ();

  audio_dac_out #(.WATCHDOG_CYCLES(2048)) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  logic [15:0] exp_fade_in [17] = '{
    16'h0000, 16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080,
    16'h0100, 16'h0200, 16'h0400, 16'h0800, 16'h1000, 16'h2000, 16'h4000, 16'h4000
  };
  logic [4:0]  exp_atten_out [4] = '{5'd1, 5'd2, 5'd3, 5'd4};
  logic [15:0] exp_hold_out  [4] = '{16'hC000, 16'hE000, 16'hF000, 16'hF800};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic strobe(input logic [15:0] d);
    @(negedge clk_in);
    bus.data_in       = d;
    bus.data_valid_in = 1'b1;
    @(negedge clk_in);
    bus.data_valid_in = 1'b0;
  endtask

  task automatic count_ones(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk_in);
      cnt += int'(bus.pdm_out);
    end
  endtask

  initial begin
    bus.data_in       = 16'h0000;
    bus.data_valid_in = 1'b0;
    bus.mute_in       = 1'b0;
    reset_in          = 1'b1;
    repeat (3) @(negedge clk_in);

    check_val("rst_state",   32'(dut.state_q), 32'(MUTED));
    check_val("rst_atten",   32'(dut.atten_q), 32'd16);
    check_val("rst_hold",    $unsigned(dut.hold_q), 32'h0);
    check_val("rst_acc",     32'(dut.u_mod.acc_q), 32'h0);
    check_val("rst_pdm",     32'(bus.pdm_out), 32'd0);
    check_val("rst_muted",   32'(bus.muted_out), 32'd1);
    check_val("rst_starved", 32'(bus.starved_out), 32'd0);
`ifdef DAC_DITHER_EN
    check_val("lfsr_seed", 32'(dut.u_mod.lfsr_q), 32'hACE1);
`endif
    reset_in = 1'b0;
`ifdef DAC_DITHER_EN
    @(negedge clk_in);
    check_val("lfsr_step1", 32'(dut.u_mod.lfsr_q), 32'h59C3);
    @(negedge clk_in);
    check_val("lfsr_step2", 32'(dut.u_mod.lfsr_q), 32'hB387);
`endif

    // Fade in from power-up: 17 strobes of 0x4000
    for (int k = 0; k < 17; k++) begin
      strobe(16'h4000);
      check_val($sformatf("fadein_hold_%0d", k + 1), $unsigned(dut.hold_q), 32'(exp_fade_in[k]));
      if (k == 0) begin
        check_val("muted_lag", 32'(bus.muted_out), 32'd1);
        @(negedge clk_in);
        check_val("muted_clear", 32'(bus.muted_out), 32'd0);
      end
      if (k == 15) begin
        check_val("fadein_state_play", 32'(dut.state_q), 32'(PLAY));
        @(negedge clk_in);
        check_val("fadein_muted", 32'(bus.muted_out), 32'd0);
      end
    end
    check_val("play_atten", 32'(dut.atten_q), 32'd0);

    // Duty cycle in PLAY
    strobe(16'h0000);
    repeat (2) @(negedge clk_in);
    count_ones(4096, ones);
`ifdef DAC_DITHER_EN
    check_val("duty_zero_dither", 32'((ones >= 2040) && (ones <= 2056)), 32'd1);
`else
    check_val("duty_zero", 32'(ones), 32'd2048);
    strobe(16'h7FFF);
    repeat (2) @(negedge clk_in);
    count_ones(4096, ones);
    check_val("duty_max", 32'((ones >= 4095) && (ones <= 4096)), 32'd1);
    strobe(16'h8000);
    repeat (2) @(negedge clk_in);
    count_ones(4096, ones);
    check_val("duty_min", 32'(ones), 32'd0);
`endif

    // Fade out four steps then reverse
    bus.mute_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      strobe(16'h8000);
      check_val($sformatf("fadeout_atten_%0d", k + 1), 32'(dut.atten_q), 32'(exp_atten_out[k]));
      check_val($sformatf("fadeout_hold_%0d", k + 1), $unsigned(dut.hold_q), 32'(exp_hold_out[k]));
    end
    check_val("fadeout_state", 32'(dut.state_q), 32'(FADE_OUT));
    bus.mute_in = 1'b0;
    strobe(16'h8000);
    check_val("reverse_atten", 32'(dut.atten_q), 32'd3);
    check_val("reverse_hold",  $unsigned(dut.hold_q), 32'hF000);
    check_val("reverse_state", 32'(dut.state_q), 32'(FADE_IN));

    // Watchdog rises 2048 clocks after the last strobe; ramp holds meanwhile
    repeat (2047) @(negedge clk_in);
    check_val("wd_2047", 32'(bus.starved_out), 32'd0);
    @(negedge clk_in);
    check_val("wd_2048", 32'(bus.starved_out), 32'd1);
    check_val("wd_hold_state", 32'(dut.state_q), 32'(FADE_IN));

    // Reset in the middle of FADE_IN
    @(negedge clk_in);
    reset_in = 1'b1;
    @(negedge clk_in);
    check_val("midrst_muted",   32'(bus.muted_out), 32'd1);
    check_val("midrst_pdm",     32'(bus.pdm_out), 32'd0);
    check_val("midrst_hold",    $unsigned(dut.hold_q), 32'h0);
    check_val("midrst_acc",     32'(dut.u_mod.acc_q), 32'h0);
    check_val("midrst_starved", 32'(bus.starved_out), 32'd0);
    check_val("midrst_state",   32'(dut.state_q), 32'(MUTED));
    reset_in = 1'b0;

    // Strobe arriving in the saturating cycle keeps starved_out low
    strobe(16'h1234);
    check_val("wd2_atten", 32'(dut.atten_q), 32'd15);
    repeat (2047) @(negedge clk_in);
    check_val("wd2_pre", 32'(bus.starved_out), 32'd0);
    bus.data_in       = 16'h1234;
    bus.data_valid_in = 1'b1;
    @(negedge clk_in);
    bus.data_valid_in = 1'b0;
    check_val("wd2_collide",  32'(bus.starved_out), 32'd0);
    check_val("wd2_atten_14", 32'(dut.atten_q), 32'd14);
    repeat (2047) @(negedge clk_in);
    check_val("wd3_2047", 32'(bus.starved_out), 32'd0);
    @(negedge clk_in);
    check_val("wd3_2048", 32'(bus.starved_out), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
